// File: rtl/execute_md.sv
// Execute stage: operand forwarding, single-cycle ALU/branch, iterative shift-add multiply.
// Define EXECUTE_MD_DIV_EN to build the restoring divider; without it op 3 reports status 7.
module execute_md #(
    parameter int WIDTH      = 32,
    parameter int REGW       = 5,
    parameter int STATUS_REG = 30
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       op,
    input  logic [4:0]       aluop,
    input  logic [4:0]       shamt,
    input  logic [REGW-1:0]  rs,
    input  logic [REGW-1:0]  rt,
    input  logic [REGW-1:0]  rd,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [16:0]      imm,
    input  logic             mem_wen,
    input  logic [REGW-1:0]  mem_rd,
    input  logic [WIDTH-1:0] mem_data,
    input  logic             wb_wen,
    input  logic [REGW-1:0]  wb_rd,
    input  logic [WIDTH-1:0] wb_data,
    input  logic             flush,
    output logic             out_valid,
    output logic             out_wen,
    output logic [REGW-1:0]  out_rd,
    output logic [WIDTH-1:0] out_data,
    output logic             br_taken
);

    localparam int CW = $clog2(WIDTH + 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_MULT = 2'd1;
`ifdef EXECUTE_MD_DIV_EN
    localparam logic [1:0] S_DIV  = 2'd2;
`endif

    localparam logic [2:0] OP_ALU  = 3'd0;
    localparam logic [2:0] OP_ALUI = 3'd1;
    localparam logic [2:0] OP_MULT = 3'd2;
    localparam logic [2:0] OP_DIV  = 3'd3;
    localparam logic [2:0] OP_BNE  = 3'd4;
    localparam logic [2:0] OP_BLT  = 3'd5;

    localparam logic [4:0] ALU_ADD  = 5'd0;
    localparam logic [4:0] ALU_SUB  = 5'd1;
    localparam logic [4:0] ALU_AND  = 5'd2;
    localparam logic [4:0] ALU_OR   = 5'd3;
    localparam logic [4:0] ALU_XOR  = 5'd4;
    localparam logic [4:0] ALU_NOR  = 5'd5;
    localparam logic [4:0] ALU_SLT  = 5'd6;
    localparam logic [4:0] ALU_SLTU = 5'd7;
    localparam logic [4:0] ALU_SLL  = 5'd8;
    localparam logic [4:0] ALU_SRL  = 5'd9;
    localparam logic [4:0] ALU_SRA  = 5'd10;

    localparam logic [REGW-1:0]  ST_RD       = REGW'(STATUS_REG);
    localparam logic [WIDTH-1:0] ST_ADD_OVF  = WIDTH'(1);
    localparam logic [WIDTH-1:0] ST_SUB_OVF  = WIDTH'(2);
    localparam logic [WIDTH-1:0] ST_ADDI_OVF = WIDTH'(3);
    localparam logic [WIDTH-1:0] ST_MUL_OVF  = WIDTH'(4);
`ifdef EXECUTE_MD_DIV_EN
    localparam logic [WIDTH-1:0] ST_DIV_ZERO = WIDTH'(5);
    localparam logic [WIDTH-1:0] ST_DIV_OVF  = WIDTH'(6);
`else
    localparam logic [WIDTH-1:0] ST_NO_DIV   = WIDTH'(7);
`endif

    logic [1:0]       state;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] acc_hi;
    logic [WIDTH-1:0] acc_lo;
    logic [WIDTH-1:0] mcand;
    logic             neg;
    logic [REGW-1:0]  iter_rd;
`ifdef EXECUTE_MD_DIV_EN
    logic             div_min;
    logic [WIDTH:0]   rem_sh;
    logic [WIDTH:0]   trial;
    logic [WIDTH-1:0] div_hi_n;
    logic [WIDTH-1:0] div_lo_n;
    logic [WIDTH-1:0] quo;
`endif

    logic             accept;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic [WIDTH-1:0] op_b_fwd;
    logic [WIDTH-1:0] imm_ext;
    logic [4:0]       alu_sel;
    logic [WIDTH-1:0] sum;
    logic [WIDTH-1:0] diff;
    logic [WIDTH-1:0] alu_res;
    logic             add_ovf;
    logic             sub_ovf;
    logic [WIDTH-1:0] mag_a;
    logic [WIDTH-1:0] mag_b;

    logic             iss_wen;
    logic [REGW-1:0]  iss_rd;
    logic [WIDTH-1:0] iss_data;
    logic             iss_br;
    logic [1:0]       iss_next;

    logic [WIDTH:0]     mul_sum;
    logic [WIDTH-1:0]   mul_hi_n;
    logic [WIDTH-1:0]   mul_lo_n;
    logic [2*WIDTH-1:0] prod_s;
    logic               mul_ovf;

    logic             last_iter;
    logic             fin_wen;
    logic [REGW-1:0]  fin_rd;
    logic [WIDTH-1:0] fin_data;

    function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v);
        return v[WIDTH-1] ? -v : v;
    endfunction

    assign in_ready  = reset && (state == S_IDLE) && !flush;
    assign accept    = in_valid && in_ready;
    assign last_iter = (cnt == CW'(WIDTH - 1));

    // Memory stage outranks writeback because it holds the younger value.
    always_comb begin
        op_a = A;
        if (rs != '0 && mem_wen && mem_rd == rs)
            op_a = mem_data;
        else if (rs != '0 && wb_wen && wb_rd == rs)
            op_a = wb_data;
        op_b_fwd = B;
        if (rt != '0 && mem_wen && mem_rd == rt)
            op_b_fwd = mem_data;
        else if (rt != '0 && wb_wen && wb_rd == rt)
            op_b_fwd = wb_data;
    end

    assign imm_ext = WIDTH'($signed(imm));
    assign op_b    = (op == OP_ALUI) ? imm_ext : op_b_fwd;
    assign alu_sel = (op == OP_ALUI) ? ALU_ADD : aluop;
    assign mag_a   = magnitude(op_a);
    assign mag_b   = magnitude(op_b);

    always_comb begin
        sum     = op_a + op_b;
        diff    = op_a - op_b;
        add_ovf = (op_a[WIDTH-1] == op_b[WIDTH-1]) && (sum[WIDTH-1] != op_a[WIDTH-1]);
        sub_ovf = (op_a[WIDTH-1] != op_b[WIDTH-1]) && (diff[WIDTH-1] != op_a[WIDTH-1]);
        case (alu_sel)
            ALU_ADD:  alu_res = sum;
            ALU_SUB:  alu_res = diff;
            ALU_AND:  alu_res = op_a & op_b;
            ALU_OR:   alu_res = op_a | op_b;
            ALU_XOR:  alu_res = op_a ^ op_b;
            ALU_NOR:  alu_res = ~(op_a | op_b);
            ALU_SLT:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
            ALU_SLTU: alu_res = {{(WIDTH-1){1'b0}}, (op_a < op_b)};
            ALU_SLL:  alu_res = op_b << shamt;
            ALU_SRL:  alu_res = op_b >> shamt;
            ALU_SRA:  alu_res = $signed(op_b) >>> shamt;
            default:  alu_res = sum;
        endcase
    end

    // Result for single-cycle ops, or the iterative state to enter.
    always_comb begin
        iss_wen  = (rd != '0);
        iss_rd   = rd;
        iss_data = alu_res;
        iss_br   = 1'b0;
        iss_next = S_IDLE;
        case (op)
            OP_ALU: begin
                if (alu_sel == ALU_ADD && add_ovf) begin
                    iss_wen = 1'b1; iss_rd = ST_RD; iss_data = ST_ADD_OVF;
                end else if (alu_sel == ALU_SUB && sub_ovf) begin
                    iss_wen = 1'b1; iss_rd = ST_RD; iss_data = ST_SUB_OVF;
                end
            end
            OP_ALUI: begin
                if (add_ovf) begin
                    iss_wen = 1'b1; iss_rd = ST_RD; iss_data = ST_ADDI_OVF;
                end
            end
            OP_MULT: iss_next = S_MULT;
            OP_DIV: begin
`ifdef EXECUTE_MD_DIV_EN
                if (op_b == '0) begin
                    iss_wen = 1'b1; iss_rd = ST_RD; iss_data = ST_DIV_ZERO;
                end else begin
                    iss_next = S_DIV;
                end
`else
                iss_wen = 1'b1; iss_rd = ST_RD; iss_data = ST_NO_DIV;
`endif
            end
            OP_BNE: begin
                iss_wen  = 1'b0;
                iss_data = diff;
                iss_br   = (diff != '0);
            end
            OP_BLT: begin
                iss_wen  = 1'b0;
                iss_data = diff;
                iss_br   = diff[WIDTH-1];
            end
            default: begin
                iss_wen  = 1'b0;
                iss_data = '0;
            end
        endcase
    end

    // {acc_hi, acc_lo} shifts right one bit per step, adding the multiplicand on a 1 bit.
    always_comb begin
        mul_sum  = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, mcand} : '0);
        mul_hi_n = mul_sum[WIDTH:1];
        mul_lo_n = {mul_sum[0], acc_lo[WIDTH-1:1]};
        prod_s   = neg ? -{mul_hi_n, mul_lo_n} : {mul_hi_n, mul_lo_n};
        mul_ovf  = !((&prod_s[2*WIDTH-1:WIDTH-1]) || !(|prod_s[2*WIDTH-1:WIDTH-1]));
    end

`ifdef EXECUTE_MD_DIV_EN
    // acc_hi is the partial remainder; quotient bits shift into acc_lo as the dividend shifts out.
    always_comb begin
        rem_sh = {acc_hi, acc_lo[WIDTH-1]};
        trial  = rem_sh - {1'b0, mcand};
        if (!trial[WIDTH]) begin
            div_hi_n = trial[WIDTH-1:0];
            div_lo_n = {acc_lo[WIDTH-2:0], 1'b1};
        end else begin
            div_hi_n = rem_sh[WIDTH-1:0];
            div_lo_n = {acc_lo[WIDTH-2:0], 1'b0};
        end
        quo = neg ? -div_lo_n : div_lo_n;
    end
`endif

    always_comb begin
        fin_wen  = (iter_rd != '0);
        fin_rd   = iter_rd;
        fin_data = prod_s[WIDTH-1:0];
        if (state == S_MULT && mul_ovf) begin
            fin_wen = 1'b1; fin_rd = ST_RD; fin_data = ST_MUL_OVF;
        end
`ifdef EXECUTE_MD_DIV_EN
        if (state == S_DIV) begin
            fin_data = quo;
            if (div_min) begin
                fin_wen = 1'b1; fin_rd = ST_RD; fin_data = ST_DIV_OVF;
            end
        end
`endif
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state     <= S_IDLE;
            cnt       <= '0;
            acc_hi    <= '0;
            acc_lo    <= '0;
            mcand     <= '0;
            neg       <= 1'b0;
            iter_rd   <= '0;
`ifdef EXECUTE_MD_DIV_EN
            div_min   <= 1'b0;
`endif
            out_valid <= 1'b0;
            out_wen   <= 1'b0;
            out_rd    <= '0;
            out_data  <= '0;
            br_taken  <= 1'b0;
        end else if (flush) begin
            state     <= S_IDLE;
            cnt       <= '0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        if (iss_next == S_IDLE) begin
                            out_valid <= 1'b1;
                            out_wen   <= iss_wen;
                            out_rd    <= iss_rd;
                            out_data  <= iss_data;
                            br_taken  <= iss_br;
                        end else begin
                            state   <= iss_next;
                            cnt     <= '0;
                            acc_hi  <= '0;
                            iter_rd <= rd;
                            neg     <= op_a[WIDTH-1] ^ op_b[WIDTH-1];
                            mcand   <= (op == OP_MULT) ? mag_a : mag_b;
                            acc_lo  <= (op == OP_MULT) ? mag_b : mag_a;
`ifdef EXECUTE_MD_DIV_EN
                            div_min <= (op_a == {1'b1, {(WIDTH-1){1'b0}}}) && (&op_b);
`endif
                        end
                    end
                end
                S_MULT: begin
                    acc_hi <= mul_hi_n;
                    acc_lo <= mul_lo_n;
                    cnt    <= cnt + CW'(1);
                    if (last_iter) begin
                        state     <= S_IDLE;
                        out_valid <= 1'b1;
                        out_wen   <= fin_wen;
                        out_rd    <= fin_rd;
                        out_data  <= fin_data;
                        br_taken  <= 1'b0;
                    end
                end
`ifdef EXECUTE_MD_DIV_EN
                S_DIV: begin
                    acc_hi <= div_hi_n;
                    acc_lo <= div_lo_n;
                    cnt    <= cnt + CW'(1);
                    if (last_iter) begin
                        state     <= S_IDLE;
                        out_valid <= 1'b1;
                        out_wen   <= fin_wen;
                        out_rd    <= fin_rd;
                        out_data  <= fin_data;
                        br_taken  <= 1'b0;
                    end
                end
`endif
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_execute_md.sv
// Scoreboard bench for execute_md: expectations queued at issue, compared when out_valid pulses.
// Expectations for op 3 follow whether EXECUTE_MD_DIV_EN is defined.
module tb_execute_md;

    logic        clock = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  op;
    logic [4:0]  aluop;
    logic [4:0]  shamt;
    logic [4:0]  rs, rt, rd;
    logic [31:0] A, B;
    logic [16:0] imm;
    logic        mem_wen;
    logic [4:0]  mem_rd;
    logic [31:0] mem_data;
    logic        wb_wen;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        flush;
    logic        out_valid, out_wen, br_taken;
    logic [4:0]  out_rd;
    logic [31:0] out_data;

    typedef struct packed {
        logic        wen;
        logic [4:0]  rd;
        logic [31:0] data;
        logic        br;
        logic        full;
        int          due;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;
    int   ready_wait;

    execute_md #(.WIDTH(32), .REGW(5), .STATUS_REG(30)) dut (
        .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .op(op), .aluop(aluop), .shamt(shamt), .rs(rs), .rt(rt), .rd(rd),
        .A(A), .B(B), .imm(imm),
        .mem_wen(mem_wen), .mem_rd(mem_rd), .mem_data(mem_data),
        .wb_wen(wb_wen), .wb_rd(wb_rd), .wb_data(wb_data),
        .flush(flush), .out_valid(out_valid), .out_wen(out_wen), .out_rd(out_rd),
        .out_data(out_data), .br_taken(br_taken)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("[TB] FAIL %s got=%h expected=%h (cycle %0d)", tag, got, want, cyc);
        end
    endtask

    // Every out_valid pulse must match the oldest outstanding expectation, on time.
    always @(negedge clock) begin
        if (out_valid) begin
            if (sb.size() == 0) begin
                checkOutput("spurious_valid", 32'd1, 32'd0);
            end else begin
                mon_e = sb.pop_front();
                checkOutput("latency", cyc, mon_e.due);
                checkOutput("out_wen", out_wen, mon_e.wen);
                checkOutput("br_taken", br_taken, mon_e.br);
                if (mon_e.full) begin
                    checkOutput("out_rd", out_rd, mon_e.rd);
                    checkOutput("out_data", out_data, mon_e.data);
                end
            end
        end
    end

    task automatic applyStimulus(input logic [2:0] t_op, input logic [4:0] t_aluop,
                                 input logic [4:0] t_rs, input logic [4:0] t_rt, input logic [4:0] t_rd,
                                 input logic [31:0] t_a, input logic [31:0] t_b, input logic [16:0] t_imm,
                                 input logic e_wen, input logic [4:0] e_rd, input logic [31:0] e_data,
                                 input logic e_br, input logic e_full, input int lat);
        int   guard;
        exp_t e;
        guard = 0;
        @(negedge clock);
        while (!in_ready && guard < 200) begin
            @(negedge clock);
            guard++;
        end
        if (!in_ready) begin
            checkOutput("ready_timeout", 32'd0, 32'd1);
            return;
        end
        op = t_op; aluop = t_aluop; rs = t_rs; rt = t_rt; rd = t_rd;
        A = t_a; B = t_b; imm = t_imm;
        in_valid = 1'b1;
        @(posedge clock);
        #1;
        in_valid = 1'b0;
        if (lat > 0) begin
            e.wen = e_wen; e.rd = e_rd; e.data = e_data; e.br = e_br; e.full = e_full;
            e.due = cyc + lat - 1;
            sb.push_back(e);
        end
    endtask

    initial begin
        reset = 1'b0; in_valid = 1'b0; flush = 1'b0;
        op = '0; aluop = '0; shamt = '0; rs = '0; rt = '0; rd = '0;
        A = '0; B = '0; imm = '0;
        mem_wen = 1'b0; mem_rd = '0; mem_data = '0;
        wb_wen = 1'b0; wb_rd = '0; wb_data = '0;

        repeat (2) @(posedge clock);
        @(negedge clock);
        checkOutput("rst_out_valid", out_valid, 32'd0);
        checkOutput("rst_out_wen", out_wen, 32'd0);
        checkOutput("rst_out_rd", out_rd, 32'd0);
        checkOutput("rst_out_data", out_data, 32'd0);
        checkOutput("rst_br_taken", br_taken, 32'd0);
        reset = 1'b1;
        @(negedge clock);
        checkOutput("rst_in_ready", in_ready, 32'd1);

        // Single-cycle ALU ops, overflow to the status register, immediate forms.
        applyStimulus(3'd0, 5'd0, 5'd1, 5'd2, 5'd3, 32'h7FFFFFFF, 32'd1, 17'd0, 1'b1, 5'd30, 32'd1, 1'b0, 1'b1, 1);
        applyStimulus(3'd0, 5'd0, 5'd1, 5'd2, 5'd4, 32'd5, 32'd7, 17'd0, 1'b1, 5'd4, 32'd12, 1'b0, 1'b1, 1);
        applyStimulus(3'd0, 5'd1, 5'd1, 5'd2, 5'd5, 32'h80000000, 32'd1, 17'd0, 1'b1, 5'd30, 32'd2, 1'b0, 1'b1, 1);
        applyStimulus(3'd0, 5'd1, 5'd1, 5'd2, 5'd5, 32'd20, 32'd5, 17'd0, 1'b1, 5'd5, 32'd15, 1'b0, 1'b1, 1);
        applyStimulus(3'd1, 5'd5, 5'd1, 5'd2, 5'd6, 32'h7FFFFFFF, 32'd99, 17'd1, 1'b1, 5'd30, 32'd3, 1'b0, 1'b1, 1);
        applyStimulus(3'd1, 5'd3, 5'd1, 5'd2, 5'd6, 32'd10, 32'd99, 17'h1FFFD, 1'b1, 5'd6, 32'd7, 1'b0, 1'b1, 1);
        shamt = 5'd4;
        applyStimulus(3'd0, 5'd8, 5'd1, 5'd2, 5'd7, 32'd0, 32'd3, 17'd0, 1'b1, 5'd7, 32'd48, 1'b0, 1'b1, 1);
        shamt = 5'd0;
        applyStimulus(3'd0, 5'd0, 5'd1, 5'd2, 5'd0, 32'd5, 32'd7, 17'd0, 1'b0, 5'd0, 32'd12, 1'b0, 1'b1, 1);

        // Forwarding priority: memory stage, then writeback, never for register 0.
        mem_wen = 1'b1; mem_rd = 5'd5; mem_data = 32'd10;
        wb_wen = 1'b1; wb_rd = 5'd5; wb_data = 32'd20;
        applyStimulus(3'd0, 5'd0, 5'd5, 5'd0, 5'd8, 32'd3, 32'd0, 17'd0, 1'b1, 5'd8, 32'd10, 1'b0, 1'b1, 1);
        applyStimulus(3'd0, 5'd0, 5'd1, 5'd5, 5'd8, 32'd3, 32'd0, 17'd0, 1'b1, 5'd8, 32'd13, 1'b0, 1'b1, 1);
        mem_wen = 1'b0;
        applyStimulus(3'd0, 5'd0, 5'd5, 5'd0, 5'd8, 32'd3, 32'd0, 17'd0, 1'b1, 5'd8, 32'd20, 1'b0, 1'b1, 1);
        mem_wen = 1'b1; mem_rd = 5'd0; wb_rd = 5'd0;
        applyStimulus(3'd0, 5'd0, 5'd0, 5'd0, 5'd8, 32'd3, 32'd0, 17'd0, 1'b1, 5'd8, 32'd3, 1'b0, 1'b1, 1);
        mem_wen = 1'b0; wb_wen = 1'b0;

        // Branches: result register and data are not architecturally visible.
        applyStimulus(3'd4, 5'd0, 5'd1, 5'd2, 5'd12, 32'd3, 32'd3, 17'd0, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0, 1);
        applyStimulus(3'd4, 5'd0, 5'd1, 5'd2, 5'd12, 32'd3, 32'd4, 17'd0, 1'b0, 5'd0, 32'd0, 1'b1, 1'b0, 1);
        applyStimulus(3'd5, 5'd0, 5'd1, 5'd2, 5'd12, 32'hFFFFFFFF, 32'd0, 17'd0, 1'b0, 5'd0, 32'd0, 1'b1, 1'b0, 1);
        applyStimulus(3'd5, 5'd0, 5'd1, 5'd2, 5'd12, 32'd5, 32'd3, 17'd0, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0, 1);

        // Multiply: latency, busy window, overflow and most-negative boundary.
        applyStimulus(3'd2, 5'd0, 5'd1, 5'd2, 5'd9, 32'hFFFFFFF9, 32'd6, 17'd0, 1'b1, 5'd9, 32'hFFFFFFD6, 1'b0, 1'b1, 33);
        ready_wait = 0;
        @(negedge clock);
        while (!in_ready && ready_wait < 100) begin
            ready_wait++;
            @(negedge clock);
        end
        checkOutput("mult_busy_cycles", ready_wait, 32'd32);
        applyStimulus(3'd2, 5'd0, 5'd1, 5'd2, 5'd9, 32'h00010000, 32'h00010000, 17'd0, 1'b1, 5'd30, 32'd4, 1'b0, 1'b1, 33);
        applyStimulus(3'd2, 5'd0, 5'd1, 5'd2, 5'd10, 32'h80000000, 32'd1, 17'd0, 1'b1, 5'd10, 32'h80000000, 1'b0, 1'b1, 33);
        applyStimulus(3'd2, 5'd0, 5'd1, 5'd2, 5'd11, 32'hFFFFFFFD, 32'hFFFFFFFB, 17'd0, 1'b1, 5'd11, 32'd15, 1'b0, 1'b1, 33);

`ifdef EXECUTE_MD_DIV_EN
        applyStimulus(3'd3, 5'd0, 5'd1, 5'd2, 5'd6, 32'hFFFFFFF9, 32'd2, 17'd0, 1'b1, 5'd6, 32'hFFFFFFFD, 1'b0, 1'b1, 33);
        applyStimulus(3'd3, 5'd0, 5'd1, 5'd2, 5'd6, 32'd100, 32'd7, 17'd0, 1'b1, 5'd6, 32'd14, 1'b0, 1'b1, 33);
        applyStimulus(3'd3, 5'd0, 5'd1, 5'd2, 5'd6, 32'd9, 32'd0, 17'd0, 1'b1, 5'd30, 32'd5, 1'b0, 1'b1, 1);
        applyStimulus(3'd3, 5'd0, 5'd1, 5'd2, 5'd6, 32'h80000000, 32'hFFFFFFFF, 17'd0, 1'b1, 5'd30, 32'd6, 1'b0, 1'b1, 33);
`else
        applyStimulus(3'd3, 5'd0, 5'd1, 5'd2, 5'd6, 32'hFFFFFFF9, 32'd2, 17'd0, 1'b1, 5'd30, 32'd7, 1'b0, 1'b1, 1);
`endif
        applyStimulus(3'd0, 5'd0, 5'd1, 5'd2, 5'd13, 32'd40, 32'd2, 17'd0, 1'b1, 5'd13, 32'd42, 1'b0, 1'b1, 1);

        // Flush mid-multiply: nothing may complete, ready returns at once.
        applyStimulus(3'd2, 5'd0, 5'd1, 5'd2, 5'd14, 32'd3, 32'd3, 17'd0, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0, 0);
        repeat (9) @(negedge clock);
        flush = 1'b1;
        @(posedge clock);
        #1;
        flush = 1'b0;
        @(negedge clock);
        checkOutput("flush_in_ready", in_ready, 32'd1);
        repeat (40) @(negedge clock);

        // Flush together with in_valid accepts nothing.
        op = 3'd0; aluop = 5'd0; rs = 5'd1; rt = 5'd2; rd = 5'd15; A = 32'd1; B = 32'd1;
        in_valid = 1'b1; flush = 1'b1;
        @(posedge clock);
        #1;
        in_valid = 1'b0; flush = 1'b0;
        repeat (3) @(negedge clock);

        // Reset in the middle of an iterative op clears everything, no completion.
`ifdef EXECUTE_MD_DIV_EN
        applyStimulus(3'd3, 5'd0, 5'd1, 5'd2, 5'd16, 32'd50, 32'd5, 17'd0, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0, 0);
`else
        applyStimulus(3'd2, 5'd0, 5'd1, 5'd2, 5'd16, 32'd50, 32'd5, 17'd0, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0, 0);
`endif
        repeat (5) @(negedge clock);
        reset = 1'b0;
        @(posedge clock);
        #1;
        @(negedge clock);
        checkOutput("midrst_out_valid", out_valid, 32'd0);
        checkOutput("midrst_out_wen", out_wen, 32'd0);
        checkOutput("midrst_out_rd", out_rd, 32'd0);
        checkOutput("midrst_out_data", out_data, 32'd0);
        checkOutput("midrst_br_taken", br_taken, 32'd0);
        reset = 1'b1;
        @(negedge clock);
        checkOutput("midrst_in_ready", in_ready, 32'd1);
        repeat (40) @(negedge clock);

        applyStimulus(3'd0, 5'd0, 5'd1, 5'd2, 5'd17, 32'd8, 32'd9, 17'd0, 1'b1, 5'd17, 32'd17, 1'b0, 1'b1, 1);

        ready_wait = 0;
        while (sb.size() != 0 && ready_wait < 200) begin
            @(negedge clock);
            ready_wait++;
        end
        @(negedge clock);
        checkOutput("scoreboard_drained", sb.size(), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
